// File: rtl/axibram_write_if.sv
// AXI3 write-address, write-data and write-response channels between the
// GP0 master and the BRAM write slave.
//
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where both valid and ready are high; the source holds valid and its
// payload stable until that edge, and ready may depend combinationally on
// state but never on valid of the same channel.
interface axibram_write_if;
  // write address channel
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [11:0] awid;
  logic [3:0]  awlen;
  logic [1:0]  awsize;
  logic [1:0]  awburst;
  // write data channel
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [11:0] wid;
  logic        wlast;
  logic [3:0]  wstrb;
  // write response channel
  logic        bvalid;
  logic        bready;
  logic [11:0] bid;
  logic [1:0]  bresp;

  modport master (
    output awaddr, awvalid, awid, awlen, awsize, awburst,
    output wdata, wvalid, wid, wlast, wstrb,
    output bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
    input  wdata, wvalid, wid, wlast, wstrb,
    input  bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axibram_write.sv
// AXI3 write slave that sequences FIXED/INCR/WRAP bursts onto a 32-bit BRAM
// write port. AW requests are queued, each burst is announced to the address
// decoder with start_burst/pre_awaddr, beats are gated by the selected
// device's dev_ready, and one B response per burst is queued for the master.
module axibram_write #(
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    aclk,
  input  logic                    rst,
  axibram_write_if.slave          axi,
  output logic [ADDRESS_BITS-1:0] pre_awaddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic                    bram_wclk,
  output logic [ADDRESS_BITS-1:0] bram_waddr,
  output logic                    bram_wen,
  output logic [3:0]              bram_wstb,
  output logic [31:0]             bram_wdata,
  output logic                    dbg_state
);
  localparam int AB = ADDRESS_BITS;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { ST_IDLE = 1'b0, ST_BURST = 1'b1 } state_t;

  typedef struct packed {
    logic [11:0]   id;
    logic [1:0]    burst;
    logic [3:0]    len;
    logic [AB-1:0] addr;
  } aw_entry_t;

  typedef struct packed {
    logic [11:0] id;
    logic [1:0]  resp;
  } b_entry_t;

  // AW queue storage
  aw_entry_t aw_mem [4];
  logic [1:0] aw_wr, aw_rd;
  logic [2:0] aw_cnt;
  aw_entry_t  aw_head;
  logic       aw_push;

  // B queue storage
  b_entry_t   b_mem [4];
  logic [1:0] b_wr, b_rd;
  logic [2:0] b_cnt;
  b_entry_t   b_head, b_new;
  logic       b_full, b_pop;

  // active burst context
  state_t        state;
  logic [AB-1:0] cur_addr, next_addr, addr_inc, wrap_mask;
  logic [3:0]    cur_len, cur_left;
  logic [1:0]    cur_burst;
  logic [11:0]   cur_id;
  logic          cur_err;
  logic          busy, left_zero, beat, last_beat, beat_err, wrap_ok;

  // awsize, wid and the byte/upper address bits carry no information here
  logic unused_bits;
  assign unused_bits = ^{axi.awsize, axi.wid, axi.awaddr[31:AB+2], axi.awaddr[1:0]};

  // Only two outstanding AW entries are advertised, keeping headroom for
  // requests already in flight from the interconnect.
  assign aw_head     = aw_mem[aw_rd];
  assign axi.awready = aw_cnt < 3'd2;
  assign aw_push     = axi.awvalid && axi.awready;
  assign pre_awaddr  = aw_head.addr;

  assign busy      = state == ST_BURST;
  assign left_zero = cur_left == 4'd0;
  assign b_full    = b_cnt == 3'd4;
  assign axi.bvalid = b_cnt != 3'd0;
  assign b_pop     = axi.bvalid && axi.bready;

  // The final beat may only complete if its response has somewhere to go.
  assign axi.wready = busy && dev_ready && !(left_zero && b_full && !b_pop);
  assign beat       = axi.wvalid && axi.wready;
  assign last_beat  = beat && left_zero;

  // A new burst may start in the cycle the previous one finishes (no bubble).
  assign start_burst = (aw_cnt != 3'd0) && !b_full && (!busy || last_beat);

  assign beat_err = axi.wlast != left_zero;

  assign bram_wclk  = aclk;
  assign bram_waddr = cur_addr;
  assign bram_wen   = beat && (cur_burst != BURST_RSVD);
  assign bram_wstb  = axi.wstrb;
  assign bram_wdata = axi.wdata;
  assign dbg_state  = busy;

  assign b_head    = b_mem[b_rd];
  assign axi.bid   = b_head.id;
  assign axi.bresp = b_head.resp;

  // Response for the burst finishing this cycle, including this beat's wlast check.
  always_comb begin
    b_new.id   = cur_id;
    b_new.resp = (cur_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
  end

  // Next word address; WRAP with an illegal length degrades to INCR.
  always_comb begin
    wrap_mask = AB'(cur_len);
    addr_inc  = cur_addr + AB'(1);
    wrap_ok   = (cur_len == 4'd1) || (cur_len == 4'd3) ||
                (cur_len == 4'd7) || (cur_len == 4'd15);
    case (cur_burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((cur_addr & ~wrap_mask) | (addr_inc & wrap_mask))
                                       : addr_inc;
      default:     next_addr = addr_inc;
    endcase
  end

  // Burst sequencer: loads a burst on start_burst, steps address/count per beat.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      cur_len   <= 4'd0;
      cur_left  <= 4'd0;
      cur_burst <= 2'b00;
      cur_id    <= 12'd0;
      cur_err   <= 1'b0;
    end else begin
      if (beat) begin
        cur_left <= cur_left - 4'd1;
        cur_addr <= next_addr;
        cur_err  <= cur_err | beat_err;
      end
      if (start_burst) begin
        state     <= ST_BURST;
        cur_addr  <= aw_head.addr;
        cur_len   <= aw_head.len;
        cur_left  <= aw_head.len;
        cur_burst <= aw_head.burst;
        cur_id    <= aw_head.id;
        cur_err   <= aw_head.burst == BURST_RSVD;
      end else if (last_beat) begin
        state <= ST_IDLE;
      end
    end
  end

  // AW queue: push on handshake, pop when a burst starts.
  always_ff @(posedge aclk) begin
    if (rst) begin
      aw_wr  <= 2'd0;
      aw_rd  <= 2'd0;
      aw_cnt <= 3'd0;
    end else begin
      if (aw_push) begin
        aw_mem[aw_wr] <= {axi.awid, axi.awburst, axi.awlen, axi.awaddr[AB+1:2]};
        aw_wr         <= aw_wr + 2'd1;
      end
      if (start_burst) aw_rd <= aw_rd + 2'd1;
      case ({aw_push, start_burst})
        2'b10:   aw_cnt <= aw_cnt + 3'd1;
        2'b01:   aw_cnt <= aw_cnt - 3'd1;
        default: aw_cnt <= aw_cnt;
      endcase
    end
  end

  // B queue: push on the last beat of a burst, pop on B handshake.
  always_ff @(posedge aclk) begin
    if (rst) begin
      b_wr  <= 2'd0;
      b_rd  <= 2'd0;
      b_cnt <= 3'd0;
    end else begin
      if (last_beat) begin
        b_mem[b_wr] <= b_new;
        b_wr        <= b_wr + 2'd1;
      end
      if (b_pop) b_rd <= b_rd + 2'd1;
      case ({last_beat, b_pop})
        2'b10:   b_cnt <= b_cnt + 3'd1;
        2'b01:   b_cnt <= b_cnt - 3'd1;
        default: b_cnt <= b_cnt;
      endcase
    end
  end
endmodule
